// File: rtl/mem_arbiter.sv
// mem_arbiter: byte-serial controller that shares one byte-wide RAM port between
// instruction fetch (word reads) and the MEM stage (byte/half/word loads and stores).
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_abort,
  output logic [31:0]       inst_o,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_done,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [1:0]        data_len,
  input  logic [31:0]       data_wdata,
  output logic [31:0]       data_rdata,
  output logic              data_done,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr
);

  typedef enum logic [1:0] {IDLE, IFETCH, DREAD, DWRITE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        nbytes_q, nbytes_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [31:0]       buf_q, buf_d;
  logic [31:0]       inst_o_q, inst_o_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic              inst_done_q, inst_done_d;
  logic [31:0]       data_rdata_q, data_rdata_d;
  logic              data_done_q, data_done_d;
  logic [7:0]        ram_dout_q, ram_dout_d;
  logic [ADDR_W-1:0] ram_a_q, ram_a_d;
  logic              ram_wr_q, ram_wr_d;

  logic              blocked;
  logic              inst_ok;
  logic              data_win;
  logic              inst_win;
  logic [2:0]        data_n;
  logic [2:0]        next_k;
  logic [31:0]       merged;
  logic [7:0]        wbyte;

  // A completion cycle is always followed by one dead cycle before a new acceptance.
  assign blocked  = inst_done_q | data_done_q;
  assign inst_ok  = inst_req & ~inst_abort;
  assign data_win = data_req & ((DATA_FIRST != 0) | ~inst_ok);
  assign inst_win = inst_ok & ~data_win;
  assign data_n   = (data_len == 2'b00) ? 3'd1 : (data_len == 2'b01) ? 3'd2 : 3'd4;
  assign next_k   = cnt_q + 3'd1;

  // Drop the byte returned by the RAM this cycle into its little-endian lane.
  always_comb begin
    merged = buf_q;
    case (cnt_q)
      3'd1:    merged[7:0]   = ram_din;
      3'd2:    merged[15:8]  = ram_din;
      3'd3:    merged[23:16] = ram_din;
      3'd4:    merged[31:24] = ram_din;
      default: merged = buf_q;
    endcase
  end

  // Pick the store byte for the next write beat.
  always_comb begin
    case (next_k)
      3'd1:    wbyte = wdata_q[15:8];
      3'd2:    wbyte = wdata_q[23:16];
      3'd3:    wbyte = wdata_q[31:24];
      default: wbyte = wdata_q[7:0];
    endcase
  end

  // Next-state and next-output logic for the arbiter and beat sequencer.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    nbytes_d     = nbytes_q;
    cnt_d        = cnt_q;
    buf_d        = buf_q;
    inst_o_d     = inst_o_q;
    inst_pc_d    = inst_pc_q;
    inst_done_d  = 1'b0;
    data_rdata_d = data_rdata_q;
    data_done_d  = 1'b0;
    ram_dout_d   = ram_dout_q;
    ram_a_d      = '0;
    ram_wr_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (!blocked) begin
          if (data_win) begin
            addr_d   = data_addr;
            wdata_d  = data_wdata;
            nbytes_d = data_n;
            cnt_d    = 3'd0;
            buf_d    = '0;
            ram_a_d  = data_addr;
            if (data_we) begin
              state_d    = DWRITE;
              ram_wr_d   = 1'b1;
              ram_dout_d = data_wdata[7:0];
            end else begin
              state_d = DREAD;
            end
          end else if (inst_win) begin
            addr_d   = inst_addr;
            nbytes_d = 3'd4;
            cnt_d    = 3'd0;
            buf_d    = '0;
            ram_a_d  = inst_addr;
            state_d  = IFETCH;
          end
        end
      end

      IFETCH, DREAD: begin
        if ((state_q == IFETCH) && inst_abort) begin
          state_d = IDLE;
        end else begin
          cnt_d = next_k;
          if (cnt_q != 3'd0) begin
            buf_d = merged;
          end
          if (next_k < nbytes_q) begin
            ram_a_d = addr_q + ADDR_W'(next_k);
          end
          if (cnt_q == nbytes_q) begin
            state_d = IDLE;
            if (state_q == IFETCH) begin
              inst_o_d    = merged;
              inst_pc_d   = addr_q;
              inst_done_d = 1'b1;
            end else begin
              data_rdata_d = merged;
              data_done_d  = 1'b1;
            end
          end
        end
      end

      DWRITE: begin
        cnt_d = next_k;
        if (next_k < nbytes_q) begin
          ram_a_d    = addr_q + ADDR_W'(next_k);
          ram_wr_d   = 1'b1;
          ram_dout_d = wbyte;
        end else begin
          state_d     = IDLE;
          data_done_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Register all state and outputs; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      nbytes_q     <= '0;
      cnt_q        <= '0;
      buf_q        <= '0;
      inst_o_q     <= '0;
      inst_pc_q    <= '0;
      inst_done_q  <= 1'b0;
      data_rdata_q <= '0;
      data_done_q  <= 1'b0;
      ram_dout_q   <= '0;
      ram_a_q      <= '0;
      ram_wr_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      nbytes_q     <= nbytes_d;
      cnt_q        <= cnt_d;
      buf_q        <= buf_d;
      inst_o_q     <= inst_o_d;
      inst_pc_q    <= inst_pc_d;
      inst_done_q  <= inst_done_d;
      data_rdata_q <= data_rdata_d;
      data_done_q  <= data_done_d;
      ram_dout_q   <= ram_dout_d;
      ram_a_q      <= ram_a_d;
      ram_wr_q     <= ram_wr_d;
    end
  end

  assign inst_o     = inst_o_q;
  assign inst_pc    = inst_pc_q;
  assign inst_done  = inst_done_q;
  assign data_rdata = data_rdata_q;
  assign data_done  = data_done_q;
  assign ram_dout   = ram_dout_q;
  assign ram_a      = ram_a_q;
  assign ram_wr     = ram_wr_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Single-port controller between the byte-wide main RAM and two requesters: instruction fetch (word reads only) and the MEM stage (byte/half/word loads and stores).
- Serialises each access into byte beats, assembles little-endian results and pulses a one-cycle done to the winning requester.
- Sits between the pipeline and the RAM/IO bus.
- Non-preemptive: an access always runs to completion unless it is a fetch that is aborted.

Parameters:
- ADDR_W, 32, width of requester and RAM addresses.
- DATA_FIRST, 1, when 1 data wins simultaneous requests in IDLE; when 0 fetch wins.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- inst_req  input  1  fetch request, level.
- inst_addr  input  ADDR_W  fetch address.
- inst_abort  input  1  branch redirect; cancels an in-flight fetch.
- inst_o  output  32  fetched instruction.
- inst_pc  output  ADDR_W  address of inst_o.
- inst_done  output  1  one-cycle completion pulse.
- data_req  input  1  load/store request, level.
- data_we  input  1  1 = store.
- data_addr  input  ADDR_W  byte address.
- data_len  input  2  00 byte, 01 half, 10/11 word.
- data_wdata  input  32  store data; low bytes used.
- data_rdata  output  32  zero-extended load result.
- data_done  output  1  one-cycle completion pulse.
- ram_din  input  8  RAM read byte.
- ram_dout  output  8  RAM write byte.
- ram_a  output  ADDR_W  RAM byte address.
- ram_wr  output  1  RAM write enable.

Behaviour:
- All outputs registered.
- Reset: state IDLE; inst_o, inst_pc, inst_done, data_rdata, data_done, ram_dout, ram_a, ram_wr all 0. Reset mid-access drops it; no done; ram_wr 0 next cycle; bytes already written stay written.
- States: IDLE, IFETCH, DREAD, DWRITE.
- n = bytes: 1, 2, 4 for data; 4 for fetch.
- RAM timing: one-cycle read latency; ram_din in cycle c+1 = byte at ram_a of cycle c.
- Accept: in IDLE, requests sampled at the clock edge.
  - Both asserted: DATA_FIRST picks the winner; the loser waits, its request level held.
  - The accepting edge latches address, length and wdata. Requester inputs are ignored until done.
  - Cycle 0 is the first cycle after the accepting edge.
- Read (IFETCH/DREAD): ram_a = addr+k in cycle k, k = 0..n-1. Byte k sampled at end of cycle k+1 into bits [8k+7:8k].
  - Done pulses in cycle n+1 with the result; state returns to IDLE in the same cycle.
  - Word done in cycle 5. DREAD clears unused upper bytes to 0.
- Write (DWRITE): ram_a = addr+k, ram_dout = wdata[8k+7:8k], ram_wr = 1 in cycle k.
  - data_done in cycle n; ram_wr 0 from cycle n.
- Turnaround: no request is accepted at the edge ending a done cycle. The requester deasserts req during its done cycle.
  - Earliest next acceptance is the edge ending the cycle after done, so back-to-back fetches start every n+3 cycles.
- Idle bus: when not in a beat, ram_a = 0 and ram_wr = 0; ram_dout holds its last value.
- Abort:
  - inst_abort high in any IFETCH cycle: IDLE next cycle, no inst_done, inst_o/inst_pc unchanged, one idle cycle before the next acceptance.
  - inst_abort in IDLE blocks fetch acceptance that cycle.
  - inst_abort has no effect on DREAD/DWRITE.
- Hold: inst_o/inst_pc and data_rdata hold until the next completion of their own kind.
- Address arithmetic: addr+k wraps modulo 2^ADDR_W. Alignment is not checked.

Test Plan:
- Fetch 0x1000, RAM bytes 13,05,00,00 -> ram_a 0x1000..0x1003 cycles 0-3; inst_done cycle 5 only; inst_o 0x00000513, inst_pc 0x1000.
- inst_req and data_req (load word 0x2000 = 0xDEADBEEF) same edge, DATA_FIRST=1 -> data_done cycle 5 with 0xDEADBEEF; fetch accepted at the edge after the done cycle's successor; inst_done arrives later.
- Store half 0xABCD at 0x2001 -> cycle 0 ram_a 0x2001 dout CD wr 1; cycle 1 0x2002 AB wr 1; data_done cycle 2; ram_wr 0 from cycle 2.
- Load byte at 0x3000 containing 0x80 -> data_rdata 0x00000080, data_done cycle 2.
- Fetch 0x1000, inst_abort in cycle 2 -> no inst_done, inst_o unchanged, IDLE in cycle 3; new fetch 0x2000 accepted next, inst_pc 0x2000 on its done.
- rst in cycle 1 of a word store -> ram_wr 0 next cycle, no data_done, all outputs 0; a subsequent load completes normally.
